// File: rtl/cordic_pkg.sv
// cordic_pkg: constants, arctan table and FSM encoding shared by the vectoring and sin/cos CORDIC units.
package cordic_pkg;
    localparam int MAX_ITER  = 13;
    localparam int ANGLE_90  = 23040;
    localparam int ANGLE_180 = 46080;
    localparam int K_INV_Q8  = 155;
    localparam logic [16:0] ATAN_TABLE [0:MAX_ITER-1] = '{
        17'd11520, 17'd6801, 17'd3593, 17'd1824, 17'd916, 17'd458, 17'd229,
        17'd115, 17'd57, 17'd29, 17'd14, 17'd7, 17'd4
    };
    typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: combinational arctan lookup (degrees x 256) indexed by iteration number.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]  idx_i,
    output logic [16:0] atan_o
);
    assign atan_o = (idx_i < 4'(MAX_ITER)) ? ATAN_TABLE[idx_i] : '0;
endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: vectoring-mode CORDIC returning gain-compensated magnitude and atan2(y, x) in Q8.8 degrees.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int N_ITER = 13
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic        [15:0] mag_out,
    output logic signed [16:0] angle_out,
    output logic               busy,
    output logic               done
);
    localparam logic [3:0] LAST = 4'(N_ITER - 1);

    state_t             state_q, state_d;
    logic signed [17:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [17:0] xs, ys, dx, dy, za;
    logic signed [25:0] prod;
    logic        [3:0]  i_q, i_d;
    logic               zero_q, zero_d, done_q, done_d;
    logic        [15:0] mag_q, mag_d;
    logic signed [16:0] ang_q, ang_d;
    logic        [16:0] atan;

    cordic_atan_rom u_rom (.idx_i(i_q), .atan_o(atan));

    always_ff @(posedge CLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && start)      ? ITER  :
                  (state_q == ITER && i_q == LAST) ? SCALE :
                  (state_q == SCALE)               ? IDLE  : state_q;
    end

    always_comb begin
        xs     = x_in;
        ys     = y_in;
        dx     = y_q >>> i_q;
        dy     = x_q >>> i_q;
        za     = {1'b0, atan};
        prod   = x_q * $signed(26'(K_INV_Q8));
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        i_d    = i_q;
        zero_d = zero_q;
        mag_d  = mag_q;
        ang_d  = ang_q;
        done_d = 1'b0;
        if (state_q == IDLE && start) begin
            // left half-plane is pre-rotated by +/-90 so the micro-rotations always converge
            x_d    = !x_in[15] ? xs : !y_in[15] ? ys  : -ys;
            y_d    = !x_in[15] ? ys : !y_in[15] ? -xs : xs;
            z_d    = !x_in[15] ? '0 : !y_in[15] ? 18'(ANGLE_90) : 18'(-ANGLE_90);
            i_d    = '0;
            zero_d = (x_in == 16'sd0) && (y_in == 16'sd0);
        end else if (state_q == ITER) begin
            x_d = y_q[17] ? x_q - dx : x_q + dx;
            y_d = y_q[17] ? y_q + dy : y_q - dy;
            z_d = y_q[17] ? z_q - za : z_q + za;
            i_d = (i_q == LAST) ? i_q : i_q + 4'd1;
        end else if (state_q == SCALE) begin
            mag_d  = zero_q ? '0 : 16'(prod >>> 8);
            ang_d  = zero_q ? '0 : z_q[16:0];
            done_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            i_q    <= '0;
            zero_q <= 1'b0;
            mag_q  <= '0;
            ang_q  <= '0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            zero_q <= zero_d;
            mag_q  <= mag_d;
            ang_q  <= ang_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        mag_out   = mag_q;
        angle_out = ang_q;
    end
endmodule
